// File: rtl/dr_alm_dot_acc.sv
// Signed dot-product accumulator behind an approximate log multiplier.
// It counts a fixed number of product transfers, saturates the running sum and holds the result until it is accepted.
module dr_alm_dot_acc #(
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned ACC_WIDTH = 40,
    parameter int unsigned LEN_WIDTH = 8
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic [LEN_WIDTH-1:0]   i_len,
    input  logic                   i_prod_valid,
    input  logic [2*WIDTH-1:0]     i_prod,
    output logic                   o_prod_ready,
    output logic                   o_acc_valid,
    output logic [ACC_WIDTH-1:0]   o_acc,
    output logic                   o_sat,
    input  logic                   i_acc_ready,
    output logic                   o_busy
);

    localparam int unsigned PW  = 2 * WIDTH;
    localparam int unsigned SW  = ACC_WIDTH + 1;
    localparam int unsigned EXT = SW - PW;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [LEN_WIDTH-1:0]   cnt_q, cnt_d;
    logic                   sat_q, sat_d;
    logic                   ready_q, valid_q, busy_q;

    logic [SW-1:0]          sum_c;
    logic                   ovf_c;
    logic [ACC_WIDTH-1:0]   rail_c;

    // One guard bit above the accumulator catches overflow; the rail follows the sign of the true sum.
    assign sum_c  = {acc_q[ACC_WIDTH-1], acc_q} + {{EXT{i_prod[PW-1]}}, i_prod};
    assign ovf_c  = sum_c[SW-1] ^ sum_c[SW-2];
    assign rail_c = sum_c[SW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                : {1'b0, {(ACC_WIDTH-1){1'b1}}};

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    acc_d   = '0;
                    sat_d   = 1'b0;
                    cnt_d   = i_len;
                    state_d = (i_len == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (i_prod_valid) begin
                    acc_d = ovf_c ? rail_c : sum_c[ACC_WIDTH-1:0];
                    sat_d = sat_q | ovf_c;
                    cnt_d = cnt_q - LEN_WIDTH'(1);
                    if (cnt_q == LEN_WIDTH'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (i_acc_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake flags are registered from the next state so no input reaches an output combinationally.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
            ready_q <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
            ready_q <= (state_d == ACCUM);
            valid_q <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign o_prod_ready = ready_q;
    assign o_acc_valid  = valid_q;
    assign o_acc        = acc_q;
    assign o_sat        = sat_q;
    assign o_busy       = busy_q;

endmodule

// File: doc/dr_alm_dot_acc.md
DR_ALM_DOT_ACC -- requirements
Module: dr_alm_dot_acc

Interface
REQ-001 SHALL have parameter WIDTH, default 16: operand width of the upstream log multiplier; each product is 2*WIDTH bits signed.
REQ-002 SHALL have parameter ACC_WIDTH, default 40: accumulator width; legal range is ACC_WIDTH >= 2*WIDTH+1.
REQ-003 SHALL have parameter LEN_WIDTH, default 8: width of the term-count field.
REQ-004 SHALL have port i_clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port i_start, input, 1 bit: one-cycle request to begin a new dot product.
REQ-007 SHALL have port i_len, input, LEN_WIDTH bits unsigned: number of products to accumulate; sampled with i_start.
REQ-008 SHALL have port i_prod_valid, input, 1 bit: i_prod is valid this cycle.
REQ-009 SHALL have port i_prod, input, 2*WIDTH bits signed: approximate product from the multiplier core output o_z.
REQ-010 SHALL have port o_prod_ready, output, 1 bit: the block accepts a product this cycle.
REQ-011 SHALL have port o_acc_valid, output, 1 bit: result is valid.
REQ-012 SHALL have port o_acc, output, ACC_WIDTH bits signed: accumulated dot product.
REQ-013 SHALL have port o_sat, output, 1 bit: result saturated during this dot product (sticky per job).
REQ-014 SHALL have port i_acc_ready, input, 1 bit: downstream accepts the result.
REQ-015 SHALL have port o_busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-016 SHALL implement the FSM states IDLE, ACCUM and DONE.
REQ-017 SHALL, in IDLE with i_start=1 and i_len>0, clear the accumulator, clear o_sat, load the remaining-term counter with i_len and go to ACCUM on the next edge.
REQ-018 SHALL, in IDLE with i_start=1 and i_len=0, go directly to DONE with o_acc=0 and o_sat=0.
REQ-019 SHALL ignore i_start in ACCUM and DONE, with no effect on the counter, the accumulator or the state.
REQ-020 SHALL drive o_prod_ready=1 only in ACCUM; a product transfers on any edge where i_prod_valid and o_prod_ready are both 1.
REQ-021 SHALL, on each transfer, sign-extend i_prod to ACC_WIDTH+1 bits, add it to the accumulator and decrement the counter.
REQ-022 SHALL saturate the sum: above 2^(ACC_WIDTH-1)-1 it clamps to that value; below -2^(ACC_WIDTH-1) it clamps to that value; o_sat is set and held until the next accepted start.
REQ-023 SHALL, after saturation, continue adding later products to the clamped value, so a later opposite-sign product may move the sum off the rail.
REQ-024 SHALL, on the transfer that takes the counter from 1 to 0, go to DONE; o_acc_valid rises in the cycle after that transfer and o_acc equals the full sum.
REQ-025 SHALL leave the accumulator and counter unchanged on cycles in ACCUM where i_prod_valid=0 (stall); there is no timeout.
REQ-026 SHALL, in DONE, hold o_acc_valid=1 and hold o_acc and o_sat stable until i_acc_ready=1, then return to IDLE on that edge.
REQ-027 SHALL drive o_acc_valid=0 in IDLE and ACCUM.
REQ-028 SHALL have no combinational path from i_acc_ready or i_prod_valid to any output.
REQ-029 SHALL take the earliest new start on the cycle after DONE exits, with no extra idle cycle required beyond IDLE itself.

Reset
REQ-030 SHALL, while i_rst=1 and regardless of the clock, force state=IDLE, accumulator=0, counter=0, o_acc=0, o_sat=0, o_acc_valid=0, o_prod_ready=0 and o_busy=0.
REQ-031 SHALL, on reset asserted mid-job in ACCUM or DONE, discard the job, emit no result, and accept a start on the first edge after i_rst deasserts.

Verification
REQ-032 SHALL be checked with WIDTH=16, ACC_WIDTH=40: start with len=3, products 100, -30, 7 back-to-back -> o_acc_valid the cycle after the third transfer, o_acc=77, o_sat=0.
REQ-033 SHALL be checked with len=4, i_prod_valid toggling 1,0,1,0,... -> exactly 4 transfers, sum correct, o_prod_ready held throughout ACCUM.
REQ-034 SHALL be checked with ACC_WIDTH=33, len=3, products 2^31-1 three times -> o_acc=2^32-1, o_sat=1; then a new job of len=1 with product 5 -> o_acc=5, o_sat=0.
REQ-035 SHALL be checked with start and len=0 -> o_acc_valid the next cycle, o_acc=0; hold i_acc_ready=0 for 5 cycles -> output stable, and a start pulse during that window is ignored.
REQ-036 SHALL be checked with i_rst asserted between clock edges after 2 of 5 products -> outputs zero immediately; a fresh job of len=2 with products 3, 4 gives 7.
